vc_dest_router: RTL

- Stage directly downstream of the class demux and its VC0/VC1 FIFOs.
- Pops words from VC0/VC1 (VC0 has strict priority by default) and steers each word by its dest bit into the D0 or D1 FIFO.
- Stalls on downstream almost-full.
- Throughput is up to 1 word/cycle; pop-to-push latency is 2 cycles.

---
 rtl/vc_dest_router_pkg.sv | 13 +
 rtl/vc_grant_arb.sv | 48 ++++
 rtl/vc_dest_router.sv | 70 +++++++
 3 files changed

// File: rtl/vc_dest_router_pkg.sv
// Shared word-format and VC id definitions for the class demux, VC/D FIFOs
// and the destination router.
package vc_dest_router_pkg;
  localparam int PAYLOAD_MSB = 7;
  localparam int CLASS_BIT   = 8;
  localparam int DEST_BIT    = 9;
  localparam int DATA_SIZE   = 10;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_id_t;
endpackage

// File: rtl/vc_grant_arb.sv
// Combinational VC pop grant for vc_dest_router; strict VC0 priority by
// default, round-robin with a last_grant register when VC_ROUND_ROBIN_EN is defined.
module vc_grant_arb
  import vc_dest_router_pkg::*;
(
`ifdef VC_ROUND_ROBIN_EN
  input  logic clk,
`endif
  input  logic reset,
  input  logic vc0_empty,
  input  logic vc1_empty,
  input  logic stall,
  output logic pop_vc0,
  output logic pop_vc1
);

  logic can_pop;
  assign can_pop = !reset && !stall;

`ifdef VC_ROUND_ROBIN_EN
  vc_id_t last_grant;

  always_comb begin
    pop_vc0 = 1'b0;
    pop_vc1 = 1'b0;
    if (can_pop) begin
      if (!vc0_empty && !vc1_empty) begin
        // Contention: hand the grant to the VC that did not win last time.
        if (last_grant == VC0) pop_vc1 = 1'b1;
        else                   pop_vc0 = 1'b1;
      end else begin
        pop_vc0 = !vc0_empty;
        pop_vc1 = !vc1_empty;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        last_grant <= VC0;
    else if (pop_vc0) last_grant <= VC0;
    else if (pop_vc1) last_grant <= VC1;
  end
`else
  assign pop_vc0 = can_pop && !vc0_empty;
  assign pop_vc1 = can_pop && vc0_empty && !vc1_empty;
`endif

endmodule

// File: rtl/vc_dest_router.sv
// Pops VC0/VC1 FIFOs and steers each word by its dest bit into D0 or D1.
// Build option: define VC_ROUND_ROBIN_EN for round-robin VC arbitration.
module vc_dest_router #(
  parameter int DATA_SIZE = vc_dest_router_pkg::DATA_SIZE,
  parameter int DEST_BIT  = vc_dest_router_pkg::DEST_BIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] vc0_data,
  input  logic [DATA_SIZE-1:0] vc1_data,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic                 d0_almost_full,
  input  logic                 d1_almost_full,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [DATA_SIZE-1:0] d_data,
  output logic                 idle
);
  import vc_dest_router_pkg::*;

  // Dest is unknown until the word is read, so either almost-full stalls pops.
  logic stall;
  assign stall = d0_almost_full || d1_almost_full;

  vc_grant_arb u_arb (
`ifdef VC_ROUND_ROBIN_EN
    .clk       (clk),
`endif
    .reset     (reset),
    .vc0_empty (vc0_empty),
    .vc1_empty (vc1_empty),
    .stall     (stall),
    .pop_vc0   (pop_vc0),
    .pop_vc1   (pop_vc1)
  );

  logic                 s1_valid;
  vc_id_t               s1_src;
  logic [DATA_SIZE-1:0] word;

  // The VC FIFO output is registered, so the popped word appears one cycle later.
  assign word = (s1_src == VC1) ? vc1_data : vc0_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_src   <= VC0;
      push_d0  <= 1'b0;
      push_d1  <= 1'b0;
      d_data   <= '0;
    end else begin
      s1_valid <= pop_vc0 || pop_vc1;
      s1_src   <= pop_vc1 ? VC1 : VC0;
      if (s1_valid) begin
        d_data  <= word;
        push_d1 <= word[DEST_BIT];
        push_d0 <= !word[DEST_BIT];
      end else begin
        push_d0 <= 1'b0;
        push_d1 <= 1'b0;
      end
    end
  end

  assign idle = vc0_empty && vc1_empty && !s1_valid && !push_d0 && !push_d1;

endmodule
